scratchpad_server: RTL and testbench

SCRATCHPAD_SERVER -- requirements
Module: scratchpad_server

---
 rtl/kernel_mem_pkg.sv | 9 +
 rtl/scratchpad_ram.sv | 17 +
 rtl/scratchpad_server.sv | 129 ++++++++++++
 tb/tb_scratchpad_server.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/kernel_mem_pkg.sv
// kernel_mem_pkg: shared FSM encoding, window default and ready pulse value for the scratchpad server
package kernel_mem_pkg;
  typedef enum logic [2:0] {IDLE, RD_LOOK, RD_RESP, RELOAD, WR_THRU, WR_RESP} state_t;
  localparam int WIN_LOG2_DEF = 8;
  localparam logic [63:0] READY_PULSE = 64'd1;
  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return &c ? c : c + 32'd1;
  endfunction
endpackage

// File: rtl/scratchpad_ram.sv
// scratchpad_ram: single-port window storage with one-cycle synchronous read
module scratchpad_ram #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/scratchpad_server.sv
// scratchpad_server: one-window read scratchpad with full-window reload on miss and write-through to backing memory
module scratchpad_server
  import kernel_mem_pkg::*;
#(
  parameter int WIN_LOG2 = WIN_LOG2_DEF,
  parameter int DATA_WID = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                read_enable,
  input  logic                write_enable,
  input  logic [63:0]         read_addr,
  input  logic [63:0]         write_addr,
  input  logic [DATA_WID-1:0] write_data,
  input  logic                finish_read,
  input  logic                finish_write,
  output logic [63:0]         read_ready,
  output logic [63:0]         write_ready,
  output logic [DATA_WID-1:0] read_data,
  output logic                mem_rd_req,
  output logic                mem_wr_req,
  output logic [63:0]         mem_addr,
  output logic [DATA_WID-1:0] mem_wdata,
  input  logic                mem_rvalid,
  input  logic [DATA_WID-1:0] mem_rdata,
  input  logic                mem_wack,
  output logic [31:0]         hit_cnt,
  output logic [31:0]         miss_cnt,
  output logic [31:0]         err_cnt
);
  localparam int TAG_W = 62 - WIN_LOG2;
  state_t state;
  logic valid, primed, refilled, tag_hit, err, ram_we, unused;
  logic [TAG_W-1:0] tag;
  logic [WIN_LOG2-1:0] k, k_nxt, ram_a;
  logic [63:0] req_addr;
  logic [DATA_WID-1:0] req_wdata, ram_d, ram_q;
  assign k_nxt = k + WIN_LOG2'(1);
  assign tag_hit = valid && tag == req_addr[63:WIN_LOG2+2];
  assign err = state == IDLE ? read_enable && write_enable : read_enable || write_enable;
  // In IDLE the RAM is addressed straight from read_addr so the word is ready in RD_LOOK
  assign ram_a = state == RELOAD ? k : state == IDLE ? read_addr[WIN_LOG2+1:2] : req_addr[WIN_LOG2+1:2];
  assign ram_we = (state == RELOAD && mem_rvalid) || (state == WR_THRU && tag_hit);
  assign ram_d = state == RELOAD ? mem_rdata : req_wdata;
  assign unused = ^{finish_read, finish_write, req_addr[1:0]};
  scratchpad_ram #(.AW(WIN_LOG2), .DW(DATA_WID)) u_ram (
    .clk(clk), .we(ram_we), .addr(ram_a), .wdata(ram_d), .rdata(ram_q)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      valid <= 1'b0;
      primed <= 1'b0;
      refilled <= 1'b0;
      tag <= '0;
      k <= '0;
      req_addr <= '0;
      req_wdata <= '0;
      read_ready <= '0;
      write_ready <= '0;
      read_data <= '0;
      mem_rd_req <= 1'b0;
      mem_wr_req <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      hit_cnt <= '0;
      miss_cnt <= '0;
      err_cnt <= '0;
    end else begin
      read_ready <= '0;
      write_ready <= '0;
      if (err) err_cnt <= sat_inc(err_cnt);
      case (state)
        IDLE:
          if (write_enable) begin
            req_addr <= write_addr;
            req_wdata <= write_data;
            mem_wr_req <= 1'b1;
            mem_addr <= write_addr;
            mem_wdata <= write_data;
            state <= WR_THRU;
          end else if (read_enable) begin
            req_addr <= read_addr;
            primed <= 1'b1;
            refilled <= 1'b0;
            state <= RD_LOOK;
          end
        // After a reload the RAM output is stale, so spend one cycle re-reading the word
        RD_LOOK:
          if (!primed) primed <= 1'b1;
          else if (tag_hit) begin
            read_data <= ram_q;
            read_ready <= READY_PULSE;
            if (!refilled) hit_cnt <= sat_inc(hit_cnt);
            state <= RD_RESP;
          end else begin
            valid <= 1'b0;
            tag <= req_addr[63:WIN_LOG2+2];
            k <= '0;
            mem_rd_req <= 1'b1;
            mem_addr <= {req_addr[63:WIN_LOG2+2], {(WIN_LOG2+2){1'b0}}};
            miss_cnt <= sat_inc(miss_cnt);
            state <= RELOAD;
          end
        RD_RESP: state <= IDLE;
        RELOAD:
          if (mem_rvalid) begin
            k <= k_nxt;
            mem_addr <= {tag, k_nxt, 2'b00};
            if (&k) begin
              valid <= 1'b1;
              mem_rd_req <= 1'b0;
              primed <= 1'b0;
              refilled <= 1'b1;
              state <= RD_LOOK;
            end
          end
        WR_THRU:
          if (mem_wack) begin
            mem_wr_req <= 1'b0;
            write_ready <= READY_PULSE;
            state <= WR_RESP;
          end
        WR_RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_scratchpad_server.sv
// tb_scratchpad_server: directed table, corner sequences and randomized traffic against a backing-memory reference
module tb_scratchpad_server;
  logic clk = 0, reset = 1;
  logic read_enable = 0, write_enable = 0, finish_read = 0, finish_write = 0;
  logic [63:0] read_addr = 0, write_addr = 0;
  logic [31:0] write_data = 0;
  logic [63:0] read_ready, write_ready, mem_addr;
  logic [31:0] read_data, mem_wdata, mem_rdata, hit_cnt, miss_cnt, err_cnt;
  logic mem_rd_req, mem_wr_req, mem_rvalid, mem_wack;

  scratchpad_server dut (
    .clk(clk), .reset(reset), .read_enable(read_enable), .write_enable(write_enable),
    .read_addr(read_addr), .write_addr(write_addr), .write_data(write_data),
    .finish_read(finish_read), .finish_write(finish_write),
    .read_ready(read_ready), .write_ready(write_ready), .read_data(read_data),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_wack(mem_wack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  int beats = 0, rd_req_cyc = 0, wr_wait = 0, wack_delay = 3;
  bit both_hi = 0;
  logic [63:0] exp_waddr;
  logic [31:0] exp_wdata;
  logic [31:0] bmem [longint unsigned];
  logic [31:0] ref_mem [longint unsigned];

  function automatic logic [31:0] pat(input longint unsigned w);
    return (32'(w) * 32'h9E3779B1) ^ 32'h0F0F0000;
  endfunction
  function automatic logic [31:0] bk_rd(input logic [63:0] a);
    longint unsigned w = a >> 2;
    return bmem.exists(w) ? bmem[w] : pat(w);
  endfunction
  function automatic logic [31:0] ref_rd(input logic [63:0] a);
    longint unsigned w = a >> 2;
    return ref_mem.exists(w) ? ref_mem[w] : pat(w);
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Backing memory: random read beat gaps, write ack after wack_delay cycles of request
  initial begin
    mem_rvalid = 0; mem_wack = 0; mem_rdata = 0;
    forever begin
      @(negedge clk);
      mem_rvalid = 0;
      mem_wack = 0;
      if (mem_rd_req && mem_wr_req) both_hi = 1;
      if (mem_rd_req) rd_req_cyc++;
      if (mem_rd_req && !reset && $urandom_range(3) != 0) begin
        mem_rvalid = 1;
        mem_rdata = bk_rd(mem_addr);
        beats++;
      end
      if (mem_wr_req && !reset) begin
        if (wr_wait >= wack_delay) begin
          mem_wack = 1;
          chk("wr_addr", mem_addr, exp_waddr);
          chk("wr_data", 64'(mem_wdata), 64'(exp_wdata));
          bmem[mem_addr >> 2] = mem_wdata;
          wr_wait = 0;
        end else wr_wait++;
      end else wr_wait = 0;
    end
  end

  task automatic do_op(input bit wr, input logic [63:0] a, input logic [31:0] d,
                       output logic [31:0] q, output int lat);
    @(negedge clk);
    if (wr) begin
      write_enable = 1; write_addr = a; write_data = d;
      exp_waddr = a; exp_wdata = d; ref_mem[a >> 2] = d;
    end else begin
      read_enable = 1; read_addr = a;
    end
    @(negedge clk);
    read_enable = 0; write_enable = 0; lat = 1; q = 0;
    while ((wr ? write_ready : read_ready) == 0 && lat < 5000) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 5000) begin
      vectors++; miscompares++;
      $display("FAIL op_timeout: addr %0h got no ready within %0d cycles", a, lat);
      lat = -1;
    end else begin
      q = read_data;
      chk("ready_value", wr ? write_ready : read_ready, 64'd1);
      @(negedge clk);
      chk("ready_once", wr ? write_ready : read_ready, 64'd0);
    end
  endtask

  typedef struct {
    bit wr; logic [63:0] addr; logic [31:0] data; logic [31:0] exp;
    int hits; int misses; int lat;
  } vec_t;
  vec_t tbl[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] q;
    int lat, rd0, b0, rr, ww, g;
    bit mvalid;
    longint unsigned mtag, win;
    int mh, mm;
    bmem[64] = 32'hA5;
    ref_mem[64] = 32'hA5;
    tbl[0] = '{0, 64'h100, 32'h0, 32'hA5, 0, 1, 0};
    tbl[1] = '{0, 64'h104, 32'h0, pat(65), 1, 1, 2};
    tbl[2] = '{1, 64'h108, 32'hDEAD, 32'h0, 1, 1, 0};
    tbl[3] = '{0, 64'h108, 32'h0, 32'hDEAD, 2, 1, 2};
    tbl[4] = '{0, 64'h400, 32'h0, pat(256), 2, 2, 0};

    repeat (3) @(negedge clk);
    chk("rst_read_ready", read_ready, 0);
    chk("rst_write_ready", write_ready, 0);
    chk("rst_read_data", 64'(read_data), 0);
    chk("rst_mem_req", {62'd0, mem_rd_req, mem_wr_req}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", 64'(mem_wdata), 0);
    chk("rst_counters", {hit_cnt, miss_cnt} | 64'(err_cnt), 0);
    reset = 0;

    for (int i = 0; i < 5; i++) begin
      wack_delay = 3;
      rd0 = rd_req_cyc;
      do_op(tbl[i].wr, tbl[i].addr, tbl[i].data, q, lat);
      if (!tbl[i].wr) chk($sformatf("tbl%0d_data", i), 64'(q), 64'(tbl[i].exp));
      chk($sformatf("tbl%0d_hits", i), 64'(hit_cnt), 64'(tbl[i].hits));
      chk($sformatf("tbl%0d_misses", i), 64'(miss_cnt), 64'(tbl[i].misses));
      if (tbl[i].lat != 0) begin
        chk($sformatf("tbl%0d_latency", i), 64'(lat), 64'(tbl[i].lat));
        chk($sformatf("tbl%0d_no_mem_rd", i), 64'(rd_req_cyc - rd0), 0);
      end
    end

    // Simultaneous enables: the write wins, the read is dropped
    @(negedge clk);
    write_enable = 1; read_enable = 1;
    write_addr = 64'h10C; write_data = 32'h1234; read_addr = 64'h110;
    exp_waddr = 64'h10C; exp_wdata = 32'h1234; ref_mem[64'h10C >> 2] = 32'h1234;
    @(negedge clk);
    write_enable = 0; read_enable = 0; rr = 0; ww = 0;
    repeat (40) begin
      if (read_ready != 0) rr++;
      if (write_ready != 0) ww++;
      @(negedge clk);
    end
    chk("simul_no_read", 64'(rr), 0);
    chk("simul_one_write", 64'(ww), 1);
    chk("simul_err_cnt", 64'(err_cnt), 1);

    // Read request while a write is still pending is ignored
    wack_delay = 6;
    @(negedge clk);
    write_enable = 1; write_addr = 64'h404; write_data = 32'h77;
    exp_waddr = 64'h404; exp_wdata = 32'h77; ref_mem[64'h404 >> 2] = 32'h77;
    @(negedge clk);
    write_enable = 0; read_enable = 1; read_addr = 64'h400;
    @(negedge clk);
    read_enable = 0; rr = 0; ww = 0;
    repeat (40) begin
      if (read_ready != 0) rr++;
      if (write_ready != 0) ww++;
      @(negedge clk);
    end
    chk("busy_no_read", 64'(rr), 0);
    chk("busy_one_write", 64'(ww), 1);
    chk("busy_err_cnt", 64'(err_cnt), 2);
    do_op(0, 64'h404, 0, q, lat);
    chk("wr_hit_update", 64'(q), 64'h77);
    chk("wr_hit_hits", 64'(hit_cnt), 3);

    // Reset in the middle of a reload
    @(negedge clk);
    read_enable = 1; read_addr = 64'h800;
    @(negedge clk);
    read_enable = 0; b0 = beats; g = 0; rr = 0;
    while (beats - b0 < 100 && g < 2000) begin
      if (read_ready != 0) rr++;
      @(negedge clk);
      g++;
    end
    chk("abort_reached_beat100", 64'(beats - b0 >= 100), 1);
    reset = 1;
    @(negedge clk);
    chk("abort_rd_req_low", 64'(mem_rd_req), 0);
    chk("abort_counters", {hit_cnt, miss_cnt}, 0);
    reset = 0;
    repeat (10) begin
      if (read_ready != 0) rr++;
      @(negedge clk);
    end
    chk("abort_no_ready", 64'(rr), 0);
    do_op(0, 64'h800, 0, q, lat);
    chk("abort_reread_data", 64'(q), 64'(ref_rd(64'h800)));
    chk("abort_reread_miss", 64'(miss_cnt), 1);
    chk("abort_reread_hits", 64'(hit_cnt), 0);

    // Randomized traffic against the reference: window state plus backing contents
    mvalid = 1; mtag = 2; mh = 0; mm = 1; win = 2;
    for (int n = 0; n < 80; n++) begin
      logic [63:0] a;
      logic [31:0] d;
      bit wr, hit;
      if ($urandom_range(4) == 0) win = longint'($urandom_range(2));
      a = (win << 10) + 64'($urandom_range(255)) * 4;
      wr = $urandom_range(9) < 3;
      d = $urandom;
      wack_delay = $urandom_range(4);
      hit = mvalid && mtag == (a >> 10);
      do_op(wr, a, d, q, lat);
      if (!wr) begin
        if (hit) mh++;
        else begin mm++; mvalid = 1; mtag = a >> 10; end
        chk($sformatf("rnd%0d_data", n), 64'(q), 64'(ref_rd(a)));
        if (hit) chk($sformatf("rnd%0d_latency", n), 64'(lat), 2);
      end
      chk($sformatf("rnd%0d_counts", n), {hit_cnt, miss_cnt}, {32'(mh), 32'(mm)});
    end
    chk("never_both_req", 64'(both_hi), 0);
    chk("final_err_cnt", 64'(err_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
